// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares the single-port data memory between core and loader with a starvation guard
module data_mem_arbiter #(
  parameter int ADDR_W       = 13,
  parameter int DATA_W       = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_gnt,
  output logic              core_stall,
  output logic              core_rvalid,
  output logic [DATA_W-1:0] core_rdata,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic              ldr_gnt,
  output logic              ldr_rvalid,
  output logic [DATA_W-1:0] ldr_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);
  localparam int CW = STARVE_LIMIT > 1 ? $clog2(STARVE_LIMIT) : 1;
  localparam logic [CW-1:0] SAT = CW'(STARVE_LIMIT - 1);

  typedef enum logic {CORE_PRI, LDR_PRI} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     starve_q, starve_d;
  logic              rd_pend_q, rd_pend_d;
  logic              rd_owner_q, rd_owner_d;
  logic [DATA_W-1:0] core_rdata_q, core_rdata_d;
  logic [DATA_W-1:0] ldr_rdata_q, ldr_rdata_d;
  logic              ldr_denied;

  // grant selection and memory port mux; nothing is issued while reset is held
  always_comb begin
    core_gnt = 1'b0;
    ldr_gnt  = 1'b0;
    if (reset) begin
      core_gnt = (state_q == CORE_PRI) ? core_req : core_req & ~ldr_req;
      ldr_gnt  = (state_q == LDR_PRI) ? ldr_req : ldr_req & ~core_req;
    end
    core_stall = reset & core_req & ~core_gnt;
    mem_en     = core_gnt | ldr_gnt;
    mem_we     = core_gnt ? core_we : ldr_gnt & ldr_we;
    mem_addr   = core_gnt ? core_addr : ldr_gnt ? ldr_addr : '0;
    mem_din    = core_gnt ? core_wdata : ldr_gnt ? ldr_wdata : '0;
  end

  // priority state, loader starvation counter and read-return routing
  always_comb begin
    ldr_denied   = ldr_req & ~ldr_gnt;
    starve_d     = ldr_denied ? (starve_q == SAT ? starve_q : starve_q + 1'b1) : '0;
    state_d      = state_q;
    if (state_q == CORE_PRI && ldr_denied && starve_q == SAT) state_d = LDR_PRI;
    if (state_q == LDR_PRI && (ldr_gnt || !ldr_req)) state_d = CORE_PRI;
    rd_pend_d    = mem_en & ~mem_we;
    rd_owner_d   = ldr_gnt;
    core_rvalid  = rd_pend_q & ~rd_owner_q;
    ldr_rvalid   = rd_pend_q & rd_owner_q;
    core_rdata_d = core_rvalid ? mem_dout : core_rdata_q;
    ldr_rdata_d  = ldr_rvalid ? mem_dout : ldr_rdata_q;
    core_rdata   = core_rdata_d;
    ldr_rdata    = ldr_rdata_d;
  end

  // state registers; reset also kills any read issued in the cycle it asserts
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q      <= CORE_PRI;
      starve_q     <= '0;
      rd_pend_q    <= 1'b0;
      rd_owner_q   <= 1'b0;
      core_rdata_q <= '0;
      ldr_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      starve_q     <= starve_d;
      rd_pend_q    <= rd_pend_d;
      rd_owner_q   <= rd_owner_d;
      core_rdata_q <= core_rdata_d;
      ldr_rdata_q  <= ldr_rdata_d;
    end
  end
endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: directed and randomized checks of the arbiter against a behavioural model
module tb_data_mem_arbiter;
  localparam int AW  = 13;
  localparam int DW  = 16;
  localparam int LIM = 4;

  logic          CLK = 1'b0;
  logic          reset = 1'b1;
  logic          core_req = 1'b0, core_we = 1'b0;
  logic [AW-1:0] core_addr = '0;
  logic [DW-1:0] core_wdata = '0;
  logic          ldr_req = 1'b0, ldr_we = 1'b0;
  logic [AW-1:0] ldr_addr = '0;
  logic [DW-1:0] ldr_wdata = '0;
  logic          core_gnt, core_stall, core_rvalid, ldr_gnt, ldr_rvalid;
  logic [DW-1:0] core_rdata, ldr_rdata, mem_din;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_dout = '0;

  logic [DW-1:0] mem     [0:(1<<AW)-1];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];

  int checks = 0;
  int errors = 0;

  // model state: consecutive loader denials, pending read expectation, held read data
  int            run = 0;
  logic          exp_v = 1'b0, exp_own = 1'b0;
  logic [DW-1:0] exp_d = '0, last_c = '0, last_l = '0;
  logic [1:0]    mw, cw;
  logic          m_we;
  logic [AW-1:0] m_a;
  logic [DW-1:0] m_d;
  logic          rv_c, rv_l;
  logic          core_was_gnt = 1'b0, ldr_was_gnt = 1'b0;
  logic [DW-1:0] t3 [1:3];

  data_mem_arbiter dut (
    .CLK(CLK), .reset(reset),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_gnt(core_gnt), .core_stall(core_stall), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_gnt(ldr_gnt), .ldr_rvalid(ldr_rvalid), .ldr_rdata(ldr_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  always #5 CLK = ~CLK;

  function automatic logic [DW-1:0] init_val(int i);
    return DW'(i * 257) ^ 16'h5A5A;
  endfunction

  // loader wins when it asks and either the core is idle or it has been refused LIM times in a row
  function automatic logic [1:0] ref_win();
    logic l;
    l = ldr_req && (!core_req || run >= LIM);
    return {reset & core_req & ~l, reset & l};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // single-port memory with one-cycle read latency
  always @(posedge CLK) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] = mem_din;
      else mem_dout <= mem[mem_addr];
    end
  end

  // reference model advance
  always @(posedge CLK or negedge reset) begin
    if (!reset) begin
      run    = 0;
      exp_v  = 1'b0;
      last_c = '0;
      last_l = '0;
    end else begin
      if (exp_v) begin
        if (exp_own) last_l = exp_d;
        else last_c = exp_d;
      end
      mw   = ref_win();
      run  = (ldr_req && !mw[0]) ? run + 1 : 0;
      m_we = mw[1] ? core_we : ldr_we;
      m_a  = mw[1] ? core_addr : ldr_addr;
      m_d  = mw[1] ? core_wdata : ldr_wdata;
      exp_v = 1'b0;
      if (mw != 2'b00) begin
        exp_own = mw[0];
        exp_v   = !m_we;
        exp_d   = ref_mem[m_a];
        if (m_we) ref_mem[m_a] = m_d;
      end
    end
  end

  // every-cycle comparison against the model
  always @(negedge CLK) begin
    cw   = ref_win();
    rv_c = reset & exp_v & ~exp_own;
    rv_l = reset & exp_v & exp_own;
    chk("core_gnt", core_gnt, cw[1]);
    chk("ldr_gnt", ldr_gnt, cw[0]);
    chk("core_stall", core_stall, reset & core_req & ~cw[1]);
    chk("mem_en", mem_en, cw != 2'b00);
    chk("mem_we", mem_we, cw[1] ? core_we : cw[0] & ldr_we);
    chk("mem_addr", mem_addr, cw[1] ? core_addr : cw[0] ? ldr_addr : '0);
    chk("mem_din", mem_din, cw[1] ? core_wdata : cw[0] ? ldr_wdata : '0);
    chk("core_rvalid", core_rvalid, rv_c);
    chk("ldr_rvalid", ldr_rvalid, rv_l);
    chk("core_rdata", core_rdata, rv_c ? exp_d : last_c);
    chk("ldr_rdata", ldr_rdata, rv_l ? exp_d : last_l);
    core_was_gnt = core_gnt;
    ldr_was_gnt  = ldr_gnt;
  end

  // both requesters held: core for LIM cycles, forced loader grant, then core again
  task automatic starve_seq(string tag);
    core_req = 1'b1; core_we = 1'b0; core_addr = 13'h20;
    ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 13'h30;
    for (int k = 1; k <= 6; k++) begin
      #1;
      chk($sformatf("%s_core_gnt_%0d", tag, k), core_gnt, k != 5);
      chk($sformatf("%s_ldr_gnt_%0d", tag, k), ldr_gnt, k == 5);
      chk($sformatf("%s_stall_%0d", tag, k), core_stall, k == 5);
      @(posedge CLK);
      #1;
      if (k == 5) ldr_req = 1'b0;
    end
    core_req = 1'b0;
    tick();
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      mem[i]     = init_val(i);
      ref_mem[i] = init_val(i);
    end
    mem[16]     = 16'hBEEF;
    ref_mem[16] = 16'hBEEF;
    t3[1] = 16'h5B5B;
    t3[2] = 16'h5858;
    t3[3] = 16'h5959;
    #1;
    reset = 1'b0; core_req = 1'b1; core_we = 1'b0; core_addr = 13'h40;
    tick();
    tick();
    chk("t1_rst_core_gnt", core_gnt, 0);
    chk("t1_rst_mem_en", mem_en, 0);
    chk("t1_rst_core_rvalid", core_rvalid, 0);
    chk("t1_rst_ldr_rvalid", ldr_rvalid, 0);
    reset = 1'b1;
    #1 chk("t1_release_gnt", core_gnt, 1);
    tick();
    core_addr = 13'h10;
    #1 chk("t2_gnt", core_gnt, 1);
    tick();
    core_req = 1'b0;
    #1;
    chk("t2_rvalid", core_rvalid, 1);
    chk("t2_rdata", core_rdata, 16'hBEEF);
    tick();
    chk("t2_rvalid_once", core_rvalid, 0);
    for (int i = 1; i <= 3; i++) begin
      core_req = 1'b1;
      core_addr = AW'(i);
      #1 chk($sformatf("t3_gnt_%0d", i), core_gnt, 1);
      if (i > 1) chk($sformatf("t3_rdata_%0d", i - 1), {15'd0, core_rvalid, core_rdata}, {15'd1, t3[i-1]});
      tick();
    end
    core_req = 1'b0;
    #1 chk("t3_rdata_3", {15'd0, core_rvalid, core_rdata}, {15'd1, t3[3]});
    tick();
    starve_seq("t4");
    ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 13'h100; ldr_wdata = 16'h1234;
    #1 chk("t5_ldr_gnt", ldr_gnt, 1);
    tick();
    ldr_req = 1'b0;
    core_req = 1'b1; core_we = 1'b0; core_addr = 13'h100;
    #1 chk("t5_core_gnt", core_gnt, 1);
    chk("t5_ldr_rvalid_a", ldr_rvalid, 0);
    tick();
    core_req = 1'b0;
    #1;
    chk("t5_core_rvalid", core_rvalid, 1);
    chk("t5_core_rdata", core_rdata, 16'h1234);
    chk("t5_ldr_rvalid_b", ldr_rvalid, 0);
    tick();
    ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 13'h100;
    #1 chk("t6_ldr_gnt", ldr_gnt, 1);
    tick();
    ldr_req = 1'b0;
    reset = 1'b0;
    #1;
    chk("t6_ldr_rvalid", ldr_rvalid, 0);
    chk("t6_ldr_rdata", ldr_rdata, 0);
    tick();
    reset = 1'b1;
    starve_seq("t6");
    for (int it = 0; it < 3000; it++) begin
      tick();
      if (!core_req || core_was_gnt) begin
        core_req   = $urandom_range(0, 99) < 60;
        core_we    = 1'($urandom_range(0, 1));
        core_addr  = AW'($urandom_range(0, 15));
        core_wdata = DW'($urandom);
      end
      if (!ldr_req || ldr_was_gnt) begin
        ldr_req   = $urandom_range(0, 99) < 50;
        ldr_we    = 1'($urandom_range(0, 1));
        ldr_addr  = AW'($urandom_range(0, 15));
        ldr_wdata = DW'($urandom);
      end
      reset = $urandom_range(0, 199) != 0;
    end
    reset = 1'b1;
    core_req = 1'b0;
    ldr_req = 1'b0;
    tick();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
